// File: rtl/instmem_ldr.sv
// Instruction memory with a byte-stream program loader and a registered, fault-checked fetch port.
// Optional per-word even parity is enabled by defining IMEM_PARITY_EN.
module instmem_ldr #(
  parameter int unsigned ADDR_W    = 6,
  parameter string       INIT_FILE = "",
  parameter logic [31:0] NOP_WORD  = 32'h00000013
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [31:0]       a,
  input  logic              rd_en,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic              fault,
  output logic              par_err,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [7:0]        ld_data,
  input  logic              ld_valid,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef IMEM_PARITY_EN
  localparam int unsigned MemW = 33;
`else
  localparam int unsigned MemW = 32;
`endif
  localparam logic [ADDR_W:0] CntMax = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

  logic [MemW-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [31:0]       word_q, word_d;
  logic              last_q, last_d;
  logic              mem_we;
  logic [MemW-1:0]   wr_word;
  logic [MemW-1:0]   rd_word;
  logic              rd_par_bad;
  logic              fetch_acc;
  logic              fetch_fault;

  assign ld_ready = (state_q == StLoad);
  assign ld_busy  = (state_q != StIdle);
  assign ld_done  = (state_q == StDone);
  assign ld_count = cnt_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
    last_d  = last_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ld_start) begin
          state_d = StLoad;
          ptr_d   = ld_base;
          cnt_d   = '0;
          bidx_d  = '0;
          word_d  = '0;
          last_d  = 1'b0;
        end
      end
      StLoad: begin
        if (ld_valid) begin
          word_d[{bidx_q, 3'b000} +: 8] = ld_data;
          bidx_d = bidx_q + 2'd1;
          last_d = ld_last;
          if (ld_last || bidx_q == 2'd3) state_d = StWrite;
        end
      end
      StWrite: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        if (last_q) begin
          state_d = StDone;
        end else begin
          // Word buffer is cleared so a short final word is zero-padded.
          state_d = StLoad;
          bidx_d  = '0;
          word_d  = '0;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      bidx_q  <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
      last_q  <= last_d;
    end
  end

`ifdef IMEM_PARITY_EN
  assign wr_word    = {^word_q, word_q};
  assign rd_par_bad = ^rd_word;
`else
  assign wr_word    = word_q;
  assign rd_par_bad = 1'b0;
`endif

  // A reset edge landing on a write cycle abandons that word.
  always_ff @(posedge clk) begin
    if (mem_we && clrn) mem[ptr_q] <= wr_word;
  end

  assign rd_word     = mem[a[ADDR_W+1:2]];
  assign fetch_acc   = rd_en && !ld_busy;
  assign fetch_fault = (a[1:0] != 2'b00) || (a[31:ADDR_W+2] != '0);

  logic par_err_q;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      inst       <= '0;
      inst_valid <= 1'b0;
      fault      <= 1'b0;
      par_err_q  <= 1'b0;
    end else if (fetch_acc) begin
      inst       <= fetch_fault ? NOP_WORD : rd_word[31:0];
      inst_valid <= 1'b1;
      fault      <= fetch_fault;
      par_err_q  <= !fetch_fault && rd_par_bad;
    end else begin
      inst_valid <= 1'b0;
      fault      <= 1'b0;
      par_err_q  <= 1'b0;
    end
  end

`ifdef IMEM_PARITY_EN
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
  logic unused_par;
  assign unused_par = par_err_q;
`endif

endmodule

// File: tb/tb_instmem_ldr.sv
// Directed and randomized checks of instmem_ldr against a byte-queue / word-array reference model.
module tb_instmem_ldr;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              clrn;
  logic [31:0]       a;
  logic              rd_en;
  logic [31:0]       inst;
  logic              inst_valid;
  logic              fault;
  logic              par_err;
  logic              ld_start;
  logic [ADDR_W-1:0] ld_base;
  logic [7:0]        ld_data;
  logic              ld_valid;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_busy;
  logic              ld_done;
  logic [ADDR_W:0]   ld_count;

  instmem_ldr #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .clrn(clrn), .a(a), .rd_en(rd_en), .inst(inst), .inst_valid(inst_valid),
    .fault(fault), .par_err(par_err), .ld_start(ld_start), .ld_base(ld_base),
    .ld_data(ld_data), .ld_valid(ld_valid), .ld_last(ld_last), .ld_ready(ld_ready),
    .ld_busy(ld_busy), .ld_done(ld_done), .ld_count(ld_count)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mm [DEPTH];
  logic [7:0]  lq [$];
  bit          hold_chk = 1'b0;
  logic [31:0] inst_hold;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; while a load runs with rd_en held, every dropped fetch is checked.
  task automatic step();
    logic b;
    b = ld_busy;
    @(posedge clk);
    #1;
    if (hold_chk && b) begin
      chk("drop_valid", {63'd0, inst_valid}, 64'd0);
      chk("drop_hold", {32'd0, inst}, {32'd0, inst_hold});
    end
  endtask

  task automatic fetch(input logic [31:0] addr);
    logic        f;
    logic [31:0] e;
    f = (addr % 4 != 0) || (addr >= 4 * DEPTH);
    e = f ? 32'h00000013 : mm[(addr / 4) % DEPTH];
    rd_en = 1'b1;
    a = addr;
    step();
    rd_en = 1'b0;
    chk("fetch_valid", {63'd0, inst_valid}, 64'd1);
    chk("fetch_fault", {63'd0, fault}, {63'd0, f});
    chk("fetch_inst", {32'd0, inst}, {32'd0, e});
    chk("fetch_par", {63'd0, par_err}, 64'd0);
    a = $urandom;
    step();
    chk("idle_valid", {63'd0, inst_valid}, 64'd0);
    chk("idle_fault", {63'd0, fault}, 64'd0);
    chk("idle_hold", {32'd0, inst}, {32'd0, e});
  endtask

  // Streams lq into the loader starting at word base; optionally holds rd_en at address ra.
  task automatic do_load(input int base, input bit hold, input logic [31:0] ra);
    int          n;
    int          w;
    int          exp_cnt;
    int          g;
    int          dn;
    logic [31:0] word;
    logic [31:0] pre;
    n = lq.size();
    pre = mm[(ra / 4) % DEPTH];
    w = (n + 3) / 4;
    exp_cnt = (w > DEPTH) ? DEPTH : w;
    for (int k = 0; k < w; k++) begin
      word = '0;
      for (int j = 0; j < 4; j++) if (4 * k + j < n) word[8*j +: 8] = lq[4*k+j];
      mm[(base + k) % DEPTH] = word;
    end

    ld_base = base[ADDR_W-1:0];
    ld_start = 1'b1;
    rd_en = hold;
    a = ra;
    step();
    ld_start = 1'b0;
    if (hold) begin
      chk("start_fetch_valid", {63'd0, inst_valid}, 64'd1);
      chk("start_fetch_inst", {32'd0, inst}, {32'd0, pre});
      inst_hold = pre;
      hold_chk = 1'b1;
    end
    chk("start_busy", {63'd0, ld_busy}, 64'd1);
    chk("start_count", {57'd0, ld_count}, 64'd0);

    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        ld_valid = 1'b0;
        ld_last = 1'($urandom);
        ld_data = 8'($urandom);
        step();
      end
      g = 0;
      while (!ld_ready && g < 20) begin
        step();
        g++;
      end
      chk("ready", {63'd0, ld_ready}, 64'd1);
      ld_valid = 1'b1;
      ld_data = lq[i];
      ld_last = (i == n - 1);
      ld_start = (i > 0 && i < n - 1) ? 1'($urandom) : 1'b0;
      ld_base = ADDR_W'($urandom);
      step();
    end
    ld_valid = 1'b0;
    ld_last = 1'b0;
    ld_start = 1'b0;

    dn = 0;
    g = 0;
    while (ld_busy && g < 10) begin
      if (ld_done) dn++;
      step();
      g++;
    end
    chk("done_pulse", 64'(dn), 64'd1);
    chk("load_end_busy", {63'd0, ld_busy}, 64'd0);
    chk("load_count", {57'd0, ld_count}, 64'(exp_cnt));
    hold_chk = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pre;
    clrn = 1'b0;
    a = '0;
    rd_en = 1'b0;
    ld_start = 1'b0;
    ld_base = '0;
    ld_data = '0;
    ld_valid = 1'b0;
    ld_last = 1'b0;
    step();
    step();
    chk("rst_inst", {32'd0, inst}, 64'd0);
    chk("rst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_fault", {63'd0, fault}, 64'd0);
    chk("rst_par", {63'd0, par_err}, 64'd0);
    chk("rst_done", {63'd0, ld_done}, 64'd0);
    chk("rst_count", {57'd0, ld_count}, 64'd0);
    chk("rst_busy", {63'd0, ld_busy}, 64'd0);
    clrn = 1'b1;

    // Fill the whole array plus one extra word: wraps to word 0, count saturates.
    lq.delete();
    for (int i = 0; i < 4 * DEPTH + 4; i++) lq.push_back(8'($urandom));
    do_load(0, 1'b0, 32'd0);

    clrn = 1'b0;
    step();
    chk("rst2_count", {57'd0, ld_count}, 64'd0);
    clrn = 1'b1;
    fetch(32'h0);

    lq = '{8'h13, 8'h00, 8'h40, 8'h00};
    do_load(2, 1'b1, 32'h8);
    fetch(32'h8);
    chk("load_base2_word", {32'd0, inst}, 64'h00400013);

    lq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    do_load(DEPTH - 1, 1'b0, 32'h0);
    fetch(32'(4 * (DEPTH - 1)));
    chk("wrap_top_word", {32'd0, inst}, 64'h04030201);
    fetch(32'h0);
    chk("wrap_pad_word", {32'd0, inst}, 64'h00000605);

    fetch(32'h6);
    fetch(32'(4 * DEPTH));
    fetch(32'h8000_0000);
    fetch(32'($urandom_range(1, 3)));

    repeat (6) begin
      lq.delete();
      for (int i = 0; i < $urandom_range(1, 12); i++) lq.push_back(8'($urandom));
      if (lq.size() == 0) lq.push_back(8'hA5);
      do_load($urandom_range(0, DEPTH - 1), 1'($urandom), 32'(4 * $urandom_range(0, DEPTH - 1)));
      repeat (4) fetch(32'(4 * $urandom_range(0, DEPTH - 1)));
    end

    repeat (20) begin
      if ($urandom_range(0, 1) == 1) fetch(32'(4 * $urandom_range(0, DEPTH - 1)));
      else fetch(32'($urandom_range(0, 300)));
    end

    // Reset after two accepted bytes abandons the load without touching the target word.
    pre = mm[5];
    ld_base = 6'd5;
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_data = 8'hAA;
    step();
    ld_data = 8'hBB;
    step();
    ld_valid = 1'b0;
    clrn = 1'b0;
    step();
    chk("abort_busy", {63'd0, ld_busy}, 64'd0);
    chk("abort_count", {57'd0, ld_count}, 64'd0);
    chk("abort_done", {63'd0, ld_done}, 64'd0);
    clrn = 1'b1;
    fetch(32'd20);
    chk("abort_word", {32'd0, inst}, {32'd0, pre});

`ifdef IMEM_PARITY_EN
    dut.mem[7][32] = ~dut.mem[7][32];
    rd_en = 1'b1;
    a = 32'd28;
    step();
    rd_en = 1'b0;
    chk("par_valid", {63'd0, inst_valid}, 64'd1);
    chk("par_err", {63'd0, par_err}, 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
